// File: rtl/indicator_scan.sv
// ---------------------------------------------------------------------------
// indicator16 -- hex nibble to seven-segment decoder.
//
// Output is active-low for a common-anode display.
// Bit 7 is the decimal point and is always driven dark (1) here.
// Bits 6..0 map to segments g..a.
//
// Ports:
//   nibble_i  [3:0]  hex value to display
//   seg_o     [7:0]  active-low segment pattern {dp, g, f, e, d, c, b, a}
// ---------------------------------------------------------------------------
module indicator16 (
  input  logic [3:0] nibble_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = 8'hFF;
    case (nibble_i)
      4'h0: seg_o = 8'hC0;
      4'h1: seg_o = 8'hF9;
      4'h2: seg_o = 8'hA4;
      4'h3: seg_o = 8'hB0;
      4'h4: seg_o = 8'h99;
      4'h5: seg_o = 8'h92;
      4'h6: seg_o = 8'h82;
      4'h7: seg_o = 8'hF8;
      4'h8: seg_o = 8'h80;
      4'h9: seg_o = 8'h90;
      4'hA: seg_o = 8'h88;
      4'hB: seg_o = 8'h83;
      4'hC: seg_o = 8'hC6;
      4'hD: seg_o = 8'hA1;
      4'hE: seg_o = 8'h86;
      4'hF: seg_o = 8'h8E;
      default: seg_o = 8'hFF;
    endcase
  end

endmodule

// ---------------------------------------------------------------------------
// indicator_scan -- four-digit multiplexed seven-segment display driver.
//
// Each digit is selected for DIV clock cycles in turn, 0 -> 1 -> 2 -> 3.
// A new 16-bit value is accepted through a valid/ready handshake into a
// one-entry pending register. The value moves into the displayed shadow
// register only at the end of a full frame, so a frame never mixes old
// and new digits.
//
// Ports:
//   clk           system clock, rising-edge active
//   rst_n         asynchronous active-low reset
//   load_data_i   [15:0] four hex nibbles, nibble i shown on digit i
//   load_valid_i  producer offers load_data_i
//   load_ready_o  pending register is empty and can take a value
//   dp_mask_i     [3:0] live decimal-point request per digit (1 = lit)
//   lzb_i         live leading-zero blanking enable
//   enable_i      live display enable (0 = all digits dark)
//   segments_o    [7:0] active-low segments {dp, g..a}, registered
//   anodes_o      [3:0] active-low digit select, registered
//   frame_done_o  one-cycle pulse on the cycle after each frame boundary
// ---------------------------------------------------------------------------
module indicator_scan #(
  parameter int unsigned DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] load_data_i,
  input  logic        load_valid_i,
  output logic        load_ready_o,
  input  logic [3:0]  dp_mask_i,
  input  logic        lzb_i,
  input  logic        enable_i,
  output logic [7:0]  segments_o,
  output logic [3:0]  anodes_o,
  output logic        frame_done_o
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(DIV - 1);

  // Scan timing state
  logic [CW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;

  // Load path: one-entry pending buffer feeding the displayed shadow value
  logic [15:0]   pending_q, pending_d;
  logic          pend_full_q, pend_full_d;
  logic [15:0]   shadow_q, shadow_d;

  // Registered display outputs
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          fdone_q, fdone_d;

  logic          presc_tc;
  logic          frame_end;
  logic          load_fire;
  logic [3:0]    cur_nibble;
  logic [7:0]    dec_seg;
  logic [3:0]    zero_from;
  logic          blank;
  logic          dp_on;
  logic [3:0]    an_sel;

  assign presc_tc     = (presc_q == TERM);
  assign frame_end    = presc_tc && (idx_q == 2'd3);
  assign load_ready_o = !pend_full_q;
  assign load_fire    = load_valid_i && !pend_full_q;

  // Prescaler and digit index. The index steps only on the prescaler
  // terminal count, so every digit slot is exactly DIV cycles long.
  always_comb begin
    presc_d = presc_q + CW'(1);
    idx_d   = idx_q;
    if (presc_tc) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end
  end

  // Pending/shadow handoff. A copy at the frame boundary and a new
  // transfer can never coincide: a copy needs pend_full_q=1, which holds
  // load_ready_o low and blocks the transfer in that same cycle.
  always_comb begin
    pending_d   = pending_q;
    pend_full_d = pend_full_q;
    shadow_d    = shadow_q;
    if (frame_end && pend_full_q) begin
      shadow_d    = pending_q;
      pend_full_d = 1'b0;
    end else if (load_fire) begin
      pending_d   = load_data_i;
      pend_full_d = 1'b1;
    end
  end

  assign cur_nibble = shadow_q[{idx_q, 2'b00} +: 4];

  indicator16 u_dec (
    .nibble_i (cur_nibble),
    .seg_o    (dec_seg)
  );

  // zero_from[i] is set when shadow nibbles i..3 are all zero.
  // Digit 0 is never blanked, so its entry is tied low.
  assign zero_from[3] = (shadow_q[15:12] == 4'h0);
  assign zero_from[2] = zero_from[3] && (shadow_q[11:8] == 4'h0);
  assign zero_from[1] = zero_from[2] && (shadow_q[7:4] == 4'h0);
  assign zero_from[0] = 1'b0;

  assign blank  = lzb_i && zero_from[idx_q];
  assign dp_on  = dp_mask_i[idx_q];
  assign an_sel = ~(4'b0001 << idx_q);

  // Next display outputs come from the current index and shadow value.
  // They are then registered, so the display trails the index by one cycle.
  // A blanked digit with a lit decimal point stays selected and shows
  // only the point.
  always_comb begin
    seg_d   = 8'hFF;
    an_d    = 4'hF;
    fdone_d = frame_end;
    if (enable_i) begin
      if (!blank) begin
        seg_d = {dec_seg[7] & ~dp_on, dec_seg[6:0]};
        an_d  = an_sel;
      end else if (dp_on) begin
        seg_d = 8'h7F;
        an_d  = an_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      idx_q       <= 2'd0;
      pending_q   <= 16'h0000;
      pend_full_q <= 1'b0;
      shadow_q    <= 16'h0000;
      seg_q       <= 8'hFF;
      an_q        <= 4'hF;
      fdone_q     <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      pending_q   <= pending_d;
      pend_full_q <= pend_full_d;
      shadow_q    <= shadow_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      fdone_q     <= fdone_d;
    end
  end

  assign segments_o   = seg_q;
  assign anodes_o     = an_q;
  assign frame_done_o = fdone_q;

endmodule

// File: tb/tb_indicator_scan.sv
// ---------------------------------------------------------------------------
// tb_indicator_scan -- self-checking bench for indicator_scan with DIV=4.
//
// A cycle-level reference model keeps time as a plain tick count since
// reset release. From that count it derives the slot and frame position
// arithmetically. It checks every output after every clock.
// Hand-built frame vectors and short directed sequences cover the
// multi-cycle cases.
// ---------------------------------------------------------------------------
module tb_indicator_scan;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] loadData;
  logic        loadValid;
  logic        loadReady;
  logic [3:0]  dpMask;
  logic        lzb;
  logic        enable;
  logic [7:0]  segments;
  logic [3:0]  anodes;
  logic        frameDone;

  always #5 clk = ~clk;

  indicator_scan #(.DIV(DIV)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_data_i  (loadData),
    .load_valid_i (loadValid),
    .load_ready_o (loadReady),
    .dp_mask_i    (dpMask),
    .lzb_i        (lzb),
    .enable_i     (enable),
    .segments_o   (segments),
    .anodes_o     (anodes),
    .frame_done_o (frameDone)
  );

  typedef struct {
    logic [15:0]     data;
    logic [3:0]      dp;
    logic            lzb;
    logic [3:0][7:0] seg;
    logic [3:0][3:0] an;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  int nChecks = 0;
  int nFails  = 0;

  // Reference model state
  int          mTick;
  logic [15:0] mShadow;
  logic [15:0] mPend;
  bit          mPendFull;
  logic [7:0]  expSeg;
  logic [3:0]  expAn;
  logic        expFd;
  logic [7:0]  hexLut [16];

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeoutFail(input string name);
    nChecks++;
    nFails++;
    $display("[TB] FAIL %s: timed out at time %0t", name, $time);
  endtask

  // Predict what the outputs become at the coming edge, then advance the model
  task automatic modelStep();
    int  idx;
    bit  boundary;
    bit  upperZero;
    bit  blankIt;
    bit  dpOn;
    idx       = (mTick / DIV) % 4;
    boundary  = ((mTick % DIV) == DIV - 1) && (idx == 3);
    upperZero = 1'b1;
    for (int k = idx; k < 4; k++)
      if (mShadow[k*4 +: 4] != 4'h0) upperZero = 1'b0;
    blankIt = lzb && (idx != 0) && upperZero;
    dpOn    = dpMask[idx];
    expSeg  = 8'hFF;
    expAn   = 4'hF;
    if (enable) begin
      if (!blankIt) begin
        expSeg = hexLut[mShadow[idx*4 +: 4]];
        if (dpOn) expSeg[7] = 1'b0;
        expAn[idx] = 1'b0;
      end else if (dpOn) begin
        expSeg = 8'h7F;
        expAn[idx] = 1'b0;
      end
    end
    expFd = boundary;
    if (boundary && mPendFull) begin
      mShadow   = mPend;
      mPendFull = 1'b0;
    end else if (loadValid && !mPendFull) begin
      mPend     = loadData;
      mPendFull = 1'b1;
    end
    mTick++;
  endtask

  // One clock: model prediction, edge, then compare away from the edge
  task automatic applyStimulus();
    modelStep();
    @(posedge clk);
    #1;
    checkOutput("segments", {8'h00, segments}, {8'h00, expSeg});
    checkOutput("anodes", {12'h000, anodes}, {12'h000, expAn});
    checkOutput("frame_done", {15'h0000, frameDone}, {15'h0000, expFd});
    checkOutput("load_ready", {15'h0000, loadReady}, {15'h0000, !mPendFull});
  endtask

  task automatic doLoad(input logic [15:0] d);
    bit taken;
    taken     = 1'b0;
    loadData  = d;
    loadValid = 1'b1;
    for (int n = 0; n < 64 && !taken; n++) begin
      taken = !mPendFull;
      applyStimulus();
    end
    loadValid = 1'b0;
    if (!taken) timeoutFail("load_accept");
  endtask

  // Run until the frame boundary that copies the pending value
  task automatic waitFrame();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      applyStimulus();
      if (frameDone === 1'b1 && loadReady === 1'b1) seen = 1'b1;
    end
    if (!seen) timeoutFail("frame_boundary");
  endtask

  task automatic checkFrame(input vec_t v);
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < DIV; c++) begin
        applyStimulus();
        if (c == 0) begin
          checkOutput($sformatf("frame_seg_d%0d", s), {8'h00, segments}, {8'h00, v.seg[s]});
          checkOutput($sformatf("frame_an_d%0d", s), {12'h000, anodes}, {12'h000, v.an[s]});
        end
      end
    end
  endtask

  task automatic pulseReset();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_seg", {8'h00, segments}, 16'h00FF);
    checkOutput("rst_async_an", {12'h000, anodes}, 16'h000F);
    checkOutput("rst_async_ready", {15'h0000, loadReady}, 16'h0001);
    checkOutput("rst_async_fd", {15'h0000, frameDone}, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_held_seg", {8'h00, segments}, 16'h00FF);
    rst_n     = 1'b1;
    mTick     = 0;
    mShadow   = 16'h0000;
    mPendFull = 1'b0;
  endtask

  initial begin
    vec_t v2;
    bit   found;

    hexLut = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    vecs[0] = '{16'h12AF, 4'b0000, 1'b0, {8'hF9, 8'hA4, 8'h88, 8'h8E}, {4'h7, 4'hB, 4'hD, 4'hE}};
    vecs[1] = '{16'h0050, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'h92, 8'hC0}, {4'hF, 4'hF, 4'hD, 4'hE}};
    vecs[2] = '{16'h0050, 4'b1000, 1'b1, {8'h7F, 8'hFF, 8'h92, 8'hC0}, {4'h7, 4'hF, 4'hD, 4'hE}};
    vecs[3] = '{16'h8000, 4'b0001, 1'b1, {8'h80, 8'hC0, 8'hC0, 8'h40}, {4'h7, 4'hB, 4'hD, 4'hE}};
    vecs[4] = '{16'h0000, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hC0}, {4'hF, 4'hF, 4'hF, 4'hE}};
    vecs[5] = '{16'h0003, 4'b0110, 1'b0, {8'hC0, 8'h40, 8'h40, 8'hB0}, {4'h7, 4'hB, 4'hD, 4'hE}};
    vecs[6] = '{16'h0A00, 4'b0100, 1'b1, {8'hFF, 8'h08, 8'hC0, 8'hC0}, {4'hF, 4'hB, 4'hD, 4'hE}};

    loadData  = 16'h0000;
    loadValid = 1'b0;
    dpMask    = 4'b0000;
    lzb       = 1'b0;
    enable    = 1'b1;
    rst_n     = 1'b1;

    // Power-up reset, checked before any clock edge
    #1 rst_n = 1'b0;
    #2;
    checkOutput("por_seg", {8'h00, segments}, 16'h00FF);
    checkOutput("por_an", {12'h000, anodes}, 16'h000F);
    checkOutput("por_ready", {15'h0000, loadReady}, 16'h0001);
    checkOutput("por_fd", {15'h0000, frameDone}, 16'h0000);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    mTick     = 0;
    mShadow   = 16'h0000;
    mPendFull = 1'b0;

    // Idle scan after release
    applyStimulus();
    checkOutput("first_slot_seg", {8'h00, segments}, 16'h00C0);
    checkOutput("first_slot_an", {12'h000, anodes}, 16'h000E);
    repeat (40) applyStimulus();

    // Frame vectors: load, wait for the copy, then check a whole frame
    for (int i = 0; i < NV; i++) begin
      dpMask = vecs[i].dp;
      lzb    = vecs[i].lzb;
      doLoad(vecs[i].data);
      checkOutput("ready_after_load", {15'h0000, loadReady}, 16'h0000);
      waitFrame();
      checkFrame(vecs[i]);
    end

    // Back-to-back loads: the second stalls until the first is copied
    dpMask = 4'b0000;
    lzb    = 1'b0;
    repeat (3) applyStimulus();
    doLoad(16'h1111);
    checkOutput("b2b_stall", {15'h0000, loadReady}, 16'h0000);
    doLoad(16'h2222);
    checkOutput("b2b_first_seg", {8'h00, segments}, 16'h00F9);
    checkOutput("b2b_first_an", {12'h000, anodes}, 16'h000E);
    checkOutput("b2b_second_held", {15'h0000, loadReady}, 16'h0000);
    waitFrame();
    v2 = '{16'h2222, 4'b0000, 1'b0, {8'hA4, 8'hA4, 8'hA4, 8'hA4}, {4'h7, 4'hB, 4'hD, 4'hE}};
    checkFrame(v2);

    // Enable dropped for 10 cycles, then the display resumes in phase
    repeat (5) applyStimulus();
    enable = 1'b0;
    repeat (10) applyStimulus();
    enable = 1'b1;
    repeat (24) applyStimulus();

    // Reset in the middle of digit 2 with a load pending
    doLoad(16'hBEEF);
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      if (((mTick / DIV) % 4) == 2 && (mTick % DIV) == 1 && mPendFull) found = 1'b1;
      else applyStimulus();
    end
    if (!found) timeoutFail("reach_digit2");
    applyStimulus();
    pulseReset();
    applyStimulus();
    checkOutput("post_rst_seg", {8'h00, segments}, 16'h00C0);
    checkOutput("post_rst_ready", {15'h0000, loadReady}, 16'h0001);
    repeat (32) applyStimulus();

    // Randomized traffic against the model
    for (int n = 0; n < 1200; n++) begin
      loadValid = ($urandom_range(0, 3) == 0);
      loadData  = 16'($urandom) >> (4 * $urandom_range(0, 4));
      if ($urandom_range(0, 15) == 0) dpMask = 4'($urandom);
      if ($urandom_range(0, 31) == 0) lzb = ~lzb;
      if ($urandom_range(0, 23) == 0) enable = ~enable;
      applyStimulus();
    end
    loadValid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/indicator_scan.md
INDICATOR_SCAN -- requirements
Module: indicator_scan

Interface
REQ-001 Parameter DIV, default 50000, scan clock cycles per digit slot; legal range 2..2^20.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 load_data  input  16  four hex nibbles; nibble i (bits 4i+3..4i) is shown on digit i, with digit 3 leftmost.
REQ-005 load_valid  input  1  producer offers load_data.
REQ-006 load_ready  output  1  block can accept load_data.
REQ-007 dp_mask  input  4  live decimal-point request per digit, 1 = lit.
REQ-008 lzb  input  1  live leading-zero blanking enable.
REQ-009 enable  input  1  live display enable; 0 = all digits dark.
REQ-010 segments  output  8  active-low segment bus: bit7 = dp, bit6..bit0 = g..a.
REQ-011 anodes  output  4  active-low digit select; bit i drives digit i.
REQ-012 frame_done  output  1  one-cycle pulse at the end of each 4-digit frame.

Function
REQ-013 Prescaler counts 0..DIV-1 and wraps to 0; on its terminal count the digit index advances 0->1->2->3->0.
REQ-014 Each digit therefore stays selected for exactly DIV cycles, and a full frame lasts 4*DIV cycles.
REQ-015 Nibble decode uses the team hex decoder (indicator16), for example 0->8'hC0, 1->8'hF9, 8->8'h80, A->8'h88, F->8'h8E.
REQ-016 Bit7 of the decoder output is forced to 0 when dp_mask[index]=1.
REQ-017 segments and anodes are registered and update together, one cycle after the digit index changes; only one anode bit is 0 at any time.
REQ-018 Handshake: a transfer occurs on a cycle where load_valid=1 and load_ready=1; the transfer writes load_data into the pending register and sets pending_full.
REQ-019 load_ready equals NOT pending_full (combinational from that flag).
REQ-020 The shadow register is the only register displayed; its value changes only at a frame boundary, so no frame is ever torn.
REQ-021 Frame boundary is the cycle where index=3 and the prescaler is at its terminal count.
REQ-022 At a frame boundary with pending_full=1: pending is copied to shadow and pending_full is cleared.
REQ-023 load_ready therefore rises on the cycle after the frame boundary, and the first new digit-0 slot already shows the new value.
REQ-024 A second load offered while pending_full=1 is stalled (load_ready=0); it is never dropped or overwritten.
REQ-025 Leading-zero blanking, when lzb=1:
- digit i (i = 1..3) is dark (anodes all 1, segments 8'hFF) if shadow nibbles i..3 are all zero;
- digit 0 is never blanked;
- a lit decimal point on a blanked digit keeps that digit active, showing 8'h7F.
REQ-026 When enable=0: anodes=4'hF and segments=8'hFF from the next cycle; the prescaler, index and handshake keep running.
REQ-027 frame_done pulses high for exactly one cycle, on the cycle after each frame boundary, whether or not a load was transferred.

Reset
REQ-028 While rst_n=0, and immediately on assertion without waiting for clk:
- prescaler=0, index=0;
- shadow=16'h0000, pending_full=0 (so load_ready=1);
- segments=8'hFF, anodes=4'hF, frame_done=0.
REQ-029 On release, scanning restarts at digit 0 with a full DIV-cycle slot.
REQ-030 A reset asserted mid-frame discards any pending load and restores shadow to 0.

Verification (DIV=4)
REQ-031 Reset release with enable=1, lzb=0, no load -> anodes cycle E,D,B,7 every 4 cycles; segments=8'hC0 throughout; frame_done pulses every 16 cycles.
REQ-032 Load 16'h12AF mid-frame -> load_ready falls the next cycle; the display keeps 0000 until the boundary; the next frame shows digit0=8'h8E, digit1=8'h88, digit2=8'hA4, digit3=8'hF9; load_ready rises the cycle after the boundary.
REQ-033 Two back-to-back loads (16'h1111 then 16'h2222) -> the second is held with load_ready=0 until after the boundary; frame N+1 shows 1111 and frame N+2 shows 2222; nothing is lost.
REQ-034 lzb=1 with shadow 16'h0050 -> digits 3 and 2 dark; digit1=8'h92; digit0=8'hC0. Then set dp_mask=4'b1000 -> digit3 active with 8'h7F.
REQ-035 enable dropped for 10 cycles -> anodes=F and segments=FF throughout; frame_done timing unchanged; the display resumes in phase.
REQ-036 rst_n pulsed low mid-digit-2 with a pending load -> outputs go to FF/F asynchronously; after release shadow=0 and load_ready=1.
